// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, valid/ready on both sides.
// Optional signed saturation of the result when SERIAL_ADDSUB_SATURATE_EN is defined.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             v,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: a transfer happens on a rising edge where valid && ready; inputs are ignored otherwise.
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt, dsum_w;
    logic             carry, c_out_r, v_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    logic             cin_msb, v_nxt, last;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    logic             a_msb;
`endif

    // Digit adder; the carry into the top bit of the final digit is the carry into the MSB.
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        cin_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
        v_nxt   = cin_msb ^ dsum[DIGIT];
        dsum_w  = WIDTH'(dsum[DIGIT-1:0]);
        sum_nxt = (sum_r >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
        last    = (cnt == LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            c_out_r <= 1'b0;
            v_r     <= 1'b0;
`ifdef SERIAL_ADDSUB_SATURATE_EN
            a_msb   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b ^ {WIDTH{m}};
                    carry <= m;
                    cnt   <= '0;
`ifdef SERIAL_ADDSUB_SATURATE_EN
                    a_msb <= a[WIDTH-1];
`endif
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    sum_r <= sum_nxt;
                    if (last) begin
                        c_out_r <= dsum[DIGIT];
                        v_r     <= v_nxt;
`ifdef SERIAL_ADDSUB_SATURATE_EN
                        if (v_nxt)
                            sum_r <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign v         = v_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: 8-bit/1-bit-digit instance for directed, random, backpressure and reset cases,
// and a 4-bit/2-bit-digit instance swept exhaustively with back-to-back handshakes.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       m8, iv8, ir8, c8, v8, ov8, or8;
    logic [7:0] a8, b8, s8;
    logic       m4, iv4, ir4, c4, v4, ov4, or4;
    logic [3:0] a4, b4, s4;

    int n_vec = 0;
    int n_err = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .m(m8), .a(a8), .b(b8), .in_valid(iv8), .in_ready(ir8),
        .sum(s8), .c_out(c8), .v(v8), .out_valid(ov8), .out_ready(or8)
    );

    serial_addsub #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .m(m4), .a(a4), .b(b4), .in_valid(iv4), .in_ready(ir4),
        .sum(s4), .c_out(c4), .v(v4), .out_valid(ov4), .out_ready(or4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer add/subtract with signed range test for overflow.
    task automatic ref_op(input int w, input bit mode, input int a, input int b,
                          output int s, output bit c, output bit vv);
        int md, half, sa, sb, sr, raw;
        md   = 1 << w;
        half = md / 2;
        sa   = (a >= half) ? a - md : a;
        sb   = (b >= half) ? b - md : b;
        if (!mode) begin
            raw = a + b;
            c   = (raw >= md);
            sr  = sa + sb;
        end else begin
            raw = a - b + md;
            c   = (a >= b);
            sr  = sa - sb;
        end
        s  = raw % md;
        vv = (sr < -half) || (sr >= half);
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (vv) s = (a >= half) ? half : half - 1;
`endif
    endtask

    // One 8-bit operation; called while the DUT is idle and away from a rising edge.
    task automatic run8(input bit mode, input logic [7:0] av, input logic [7:0] bv, input int hold);
        int lat, es;
        bit ec, ev;
        check("in_ready_idle8", 32'(ir8), 32'd1);
        m8 = mode; a8 = av; b8 = bv; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom_range(255, 0)); b8 = 8'($urandom_range(255, 0)); m8 = 1'($urandom_range(1, 0));
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ref_op(8, mode, int'(av), int'(bv), es, ec, ev);
        check("latency8", 32'(lat), 32'd8);
        check("sum8", 32'(s8), 32'(es));
        check("c_out8", 32'(c8), 32'(ec));
        check("v8", 32'(v8), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            iv8 = 1'b1;
            a8 = 8'($urandom_range(255, 0)); b8 = 8'($urandom_range(255, 0));
            @(posedge clk); #1;
            check("hold_valid8", 32'(ov8), 32'd1);
            check("hold_ready8", 32'(ir8), 32'd0);
            check("hold_sum8", {22'd0, v8, c8, s8}, {22'd0, ev, ec, 8'(es)});
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("release_valid8", 32'(ov8), 32'd0);
        check("release_ready8", 32'(ir8), 32'd1);
    endtask

    initial begin
        int lat, es;
        bit ec, ev;
        rst_n = 1'b0;
        iv8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        iv4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
        #2;
        check("rst_sum", 32'(s8), 32'd0);
        check("rst_flags", {29'd0, c8, v8, ov8}, 32'd0);
        check("rst_ready", 32'(ir8), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run8(1'b0, 8'h7F, 8'h01, 0);
        run8(1'b1, 8'h05, 8'h05, 0);
        run8(1'b1, 8'h00, 8'h01, 5);
        run8(1'b1, 8'h80, 8'h01, 0);
        run8(1'b0, 8'hFF, 8'h01, 1);
        run8(1'b1, 8'h7F, 8'hFF, 0);
        for (int i = 0; i < 25; i++)
            run8(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 $urandom_range(3, 0));

        // Abort an operation mid-flight with reset, then confirm a clean restart.
        m8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(ov8), 32'd0);
        check("abort_out", {23'd0, c8, s8}, 32'd0);
        check("abort_v", 32'(v8), 32'd0);
        check("abort_ready", 32'(ir8), 32'd1);
        repeat (12) begin
            @(posedge clk); #1;
            if (ov8) check("abort_valid_hold", 32'(ov8), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        run8(1'b1, 8'h80, 8'h01, 0);

        // Exhaustive 4-bit sweep, next operands presented during DONE so handshakes run back to back.
        @(negedge clk);
        m4 = 1'b0; a4 = 4'h0; b4 = 4'h0; iv4 = 1'b1;
        for (int idx = 0; idx < 512; idx++) begin
            bit  mo;
            logic [3:0] av, bv;
            mo = idx[8]; av = idx[7:4]; bv = idx[3:0];
            @(posedge clk); #1;
            m4 = 1'($urandom_range(1, 0)); a4 = 4'($urandom_range(15, 0)); b4 = 4'($urandom_range(15, 0));
            lat = 0;
            while (!ov4 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            ref_op(4, mo, int'(av), int'(bv), es, ec, ev);
            check("latency4", 32'(lat), 32'd2);
            check("result4", {26'd0, v4, c4, s4}, {26'd0, ev, ec, 4'(es)});
            if (idx < 511) begin
                m4 = idx[8] | (idx == 255);
                {a4, b4} = 8'(idx + 1);
                m4 = ((idx + 1) >= 256);
            end else begin
                iv4 = 1'b0;
            end
            @(posedge clk); #1;
            check("ready4", {30'd0, ir4, ov4}, 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port m  input  1  mode: 0 = a+b, 1 = a-b; sampled on acceptance.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands; sampled on acceptance.
REQ-007 The block SHALL have port in_valid  input  1  operands present.
REQ-008 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-009 The block SHALL have ports sum  output  WIDTH, c_out  output  1, v  output  1: result, MSB carry-out, signed overflow.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 Acceptance SHALL occur on an edge with in_valid && in_ready: latch a, b XOR {WIDTH{m}} and m; carry := m; digit counter := 0; go to RUN.
REQ-014 Each RUN cycle SHALL add digit cnt (bits cnt*DIGIT+DIGIT-1 .. cnt*DIGIT) with the carry register, writing that sum digit and updating the carry.
REQ-015 Once the last digit (cnt == WIDTH/DIGIT-1) is processed, the block SHALL go to DONE; out_valid SHALL rise exactly WIDTH/DIGIT edges after the acceptance edge.
REQ-016 c_out SHALL be the carry out of bit WIDTH-1. For subtract, 1 = no borrow.
REQ-017 v SHALL be carry-into-MSB XOR carry-out-of-MSB (two's-complement overflow).
REQ-018 sum, c_out and v SHALL remain stable while out_valid=1.
REQ-019 In DONE the block SHALL hold until out_valid && out_ready, then go to IDLE on that edge.
REQ-020 No operands SHALL be accepted in RUN or DONE. in_valid in those states SHALL be ignored, with no queuing.
REQ-021 Operand input changes after acceptance SHALL NOT affect the result in progress.
REQ-022 Back-to-back operation: the earliest next acceptance SHALL be the edge after the handshake edge; throughput is one result per WIDTH/DIGIT+2 cycles minimum.
REQ-023 Without saturation, sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 While rst_n=0 the block SHALL be in state IDLE, with sum=0, c_out=0, v=0, out_valid=0 and in_ready=1, independent of clk.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation; the partial result SHALL be discarded, and out_valid SHALL never assert for it.
REQ-026 Reset SHALL be released synchronously to clk; the first acceptance is possible on the first edge after release.

Configuration
REQ-027 When macro SERIAL_ADDSUB_SATURATE_EN is defined and v=1, sum SHALL be signed-saturated: 0 1..1 if latched a[WIDTH-1]=0, otherwise 1 0..0; c_out and v are unchanged.
REQ-028 When SERIAL_ADDSUB_SATURATE_EN is undefined, sum SHALL be the wrapped result with no saturation logic present.

Verification
REQ-029 WIDTH=8, DIGIT=1, m=0, a=0x7F, b=0x01 -> after 8 edges out_valid=1, sum=0x80, c_out=0, v=1; with SATURATE_EN sum=0x7F.
REQ-030 WIDTH=8, m=1, a=0x05, b=0x05 -> sum=0x00, c_out=1, v=0. For a=0x00, b=0x01 -> sum=0xFF, c_out=0, v=0.
REQ-031 WIDTH=8, m=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, v=1; with SATURATE_EN sum=0x80.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0, new in_valid ignored; release -> IDLE on the next edge.
REQ-033 rst_n pulsed low 3 cycles after acceptance -> out_valid stays 0, outputs 0, in_ready=1; the following operation completes correctly.
REQ-034 WIDTH=4, DIGIT=2, all 512 (m,a,b) combinations with back-to-back handshakes -> latency 2, and sum/c_out/v match the 4-bit add/subtract reference model for every case.
